// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and helpers for the shift/add multiplier
//
// Purpose: controller state encoding and the iteration-counter width helper
//          used by shift_add_mult.
// Contents:
//   state_t   - IDLE / RUN / HOLD controller states
//   cnt_width - bits needed to count WIDTH iterations (never less than 1)
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/add_sub_n.sv
// rtl/add_sub_n.sv - (WIDTH+1)-bit adder/subtractor for the multiplier accumulator
//
// Purpose: computes ext(i_a) +/- ext(i_s), where ext() is sign extension when
//          i_sgn=1 and zero extension otherwise.
// Ports:
//   i_a      [WIDTH-1:0] accumulator operand
//   i_s      [WIDTH-1:0] multiplicand operand
//   i_fn                 0 = add, 1 = subtract
//   i_sgn                1 = two's-complement operands
//   o_result [WIDTH:0]   sum; bit WIDTH becomes the extension bit X
module add_sub_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_s,
  input  logic             i_fn,
  input  logic             i_sgn,
  output logic [WIDTH:0]   o_result
);

  logic [WIDTH:0] w_a_ext;
  logic [WIDTH:0] w_s_ext;
  logic [WIDTH:0] w_s_op;

  assign w_a_ext = {i_sgn & i_a[WIDTH-1], i_a};
  assign w_s_ext = {i_sgn & i_s[WIDTH-1], i_s};

  // Subtract as invert plus carry-in of one.
  assign w_s_op   = i_fn ? ~w_s_ext : w_s_ext;
  assign o_result = w_a_ext + w_s_op + {{WIDTH{1'b0}}, i_fn};

endmodule

// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - sequential add-and-shift multiplier, one bit per clock
//
// Purpose: 2*WIDTH-bit product of two WIDTH-bit operands, signed or unsigned,
//          with a start/busy/done handshake.
// Ports:
//   i_clk                          rising-edge clock
//   i_rst                          asynchronous active-high reset
//   i_start                        level request, sampled in IDLE and HOLD
//   i_signed_mode                  1 = two's-complement, latched at accept
//   i_multiplicand [WIDTH-1:0]     S operand, latched at accept
//   i_multiplier   [WIDTH-1:0]     B operand, latched at accept
//   o_busy                         high while iterating
//   o_done                         high while holding a valid result
//   o_product      [2*WIDTH-1:0]   {A,B}
//   o_x                            accumulator extension bit
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_signed_mode,
  input  logic [WIDTH-1:0]     i_multiplicand,
  input  logic [WIDTH-1:0]     i_multiplier,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product,
  output logic                 o_x
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t          r_state;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_x;
  logic             r_sgn;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;

  logic             w_last;
  logic             w_fn;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_acc;
  logic             w_x_shift;

  assign w_last = (r_cnt == LAST);

  // The multiplier's top bit carries negative weight in signed mode, so the
  // final partial product is subtracted instead of added.
  assign w_fn = w_last & r_sgn;

  add_sub_n #(.WIDTH(WIDTH)) u_add_sub (
    .i_a      (r_a),
    .i_s      (r_s),
    .i_fn     (w_fn),
    .i_sgn    (r_sgn),
    .o_result (w_sum)
  );

  assign w_acc = r_b[0] ? w_sum : {r_x, r_a};

  // Arithmetic shift keeps the sign in X; logical shift drops the carry into
  // A's MSB and clears X.
  assign w_x_shift = r_sgn ? w_acc[WIDTH] : 1'b0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_x     <= 1'b0;
      r_sgn   <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_s     <= i_multiplicand;
            r_b     <= i_multiplier;
            r_sgn   <= i_signed_mode;
            r_a     <= '0;
            r_x     <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          {r_x, r_a, r_b} <= {w_x_shift, w_acc, r_b[WIDTH-1:1]};
          r_cnt           <= r_cnt + CW'(1);
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          // Holding Start high parks here so one request yields one product.
          if (!i_start) begin
            r_done  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_product = {r_a, r_b};
  assign o_x       = r_x;

endmodule

// File: tb/tb_shift_add_mult.sv
// tb/tb_shift_add_mult.sv - scoreboard bench for shift_add_mult (WIDTH=8)
module tb_shift_add_mult;

  localparam int W = 8;

  logic           clk   = 1'b0;
  logic           rst   = 1'b1;
  logic           start = 1'b0;
  logic           smode = 1'b0;
  logic [W-1:0]   mc    = '0;
  logic [W-1:0]   mp    = '0;
  logic           busy;
  logic           done;
  logic           x;
  logic [2*W-1:0] prod;

  int errors     = 0;
  int checks     = 0;
  int cyc        = 0;
  int acc_cyc    = 0;
  int done_cnt   = 0;
  int busy_rises = 0;
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;
  logic [2*W-1:0] exp_q[$];

  shift_add_mult #(.WIDTH(W)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_signed_mode  (smode),
    .i_multiplicand (mc),
    .i_multiplier   (mp),
    .o_busy         (busy),
    .o_done         (done),
    .o_product      (prod),
    .o_x            (x)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: timestamps accepts and scores each rising Done against the queue.
  always @(negedge clk) begin
    if (busy && !prev_busy) begin
      acc_cyc = cyc;
      busy_rises++;
    end
    if (done && !prev_done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got product 0x%0h with nothing expected", prod);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        check("product", 32'(prod), 32'(e));
        check("latency", 32'(cyc - acc_cyc), 32'(W));
      end
    end
    prev_busy = busy;
    prev_done = done;
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [2*W-1:0] e);
    @(negedge clk);
    mc    = a;
    mp    = b;
    smode = s;
    start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: got no done within 20 cycles, expected done", name);
    end
  endtask

  task automatic run_single(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                            input logic [2*W-1:0] e, input string name);
    issue(a, b, s, e);
    wait_done(name);
    @(negedge clk);
    check({name, "_done_pulse"}, 32'(done), 32'(0));
    check({name, "_held"}, 32'(prod), 32'(e));
  endtask

  initial begin
    int d0;
    int b0;

    // Reset and idle.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_product", 32'(prod), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_x", 32'(x), 32'h0);

    // Unsigned and signed vectors, issued back to back.
    run_single(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_ff_ff");
    run_single(8'hFF, 8'hFF, 1'b1, 16'h0001, "s_ff_ff");
    run_single(8'h07, 8'hFE, 1'b1, 16'hFFF2, "s_07_fe");
    run_single(8'h80, 8'h7F, 1'b1, 16'hC080, "s_80_7f");
    run_single(8'h80, 8'h80, 1'b1, 16'h4000, "s_80_80");
    run_single(8'h7F, 8'h7F, 1'b1, 16'h3F01, "s_7f_7f");
    run_single(8'h80, 8'h80, 1'b0, 16'h4000, "u_80_80");
    run_single(8'h00, 8'hFF, 1'b0, 16'h0000, "u_00_ff");

    // Start held high with operands changed mid-run: one product only.
    d0 = done_cnt;
    b0 = busy_rises;
    @(negedge clk);
    mc    = 8'h03;
    mp    = 8'h05;
    smode = 1'b0;
    start = 1'b1;
    exp_q.push_back(16'h000F);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 3) begin
        mc    = 8'hAA;
        mp    = 8'h55;
        smode = 1'b1;
      end
    end
    check("held_done_high", 32'(done), 32'h1);
    check("held_product", 32'(prod), 32'h000F);
    check("held_busy", 32'(busy), 32'h0);
    check("held_done_count", 32'(done_cnt - d0), 32'h1);
    check("held_accept_count", 32'(busy_rises - b0), 32'h1);
    start = 1'b0;
    @(negedge clk);
    check("held_release_done", 32'(done), 32'h0);

    // Reset during iteration 4 aborts to zero immediately.
    @(negedge clk);
    mc    = 8'h12;
    mp    = 8'h34;
    smode = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_product", 32'(prod), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_x", 32'(x), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_single(8'h12, 8'h34, 1'b0, 16'h03A8, "after_abort");

    // Signed_Mode toggled during an unsigned run has no effect.
    issue(8'hFF, 8'h02, 1'b0, 16'h01FE);
    smode = 1'b1;
    @(negedge clk);
    smode = 1'b0;
    @(negedge clk);
    smode = 1'b1;
    wait_done("mode_toggle");
    @(negedge clk);
    check("mode_toggle_held", 32'(prod), 32'h01FE);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
